// File: rtl/regbus_controller_if.sv
// Handshake and bus bundle between the regbus_controller and its decode stage / register bank.
// The master modport is the controller's view; slave is the environment's view.
interface regbus_controller_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic                req_valid;
  logic                req_ready;
  logic                req_rd1;
  logic                req_rd2;
  logic                req_wr;
  logic [ADDR_W-1:0]   req_src1;
  logic [ADDR_W-1:0]   req_src2;
  logic [ADDR_W-1:0]   req_dst;
  logic [NUM_REGS-1:0] rd1_sel;
  logic [NUM_REGS-1:0] rd2_sel;
  logic [DATA_W-1:0]   bus1;
  logic [DATA_W-1:0]   bus2;
  logic [DATA_W-1:0]   op1;
  logic [DATA_W-1:0]   op2;
  logic                op_valid;
  logic                wb_valid;
  logic                wb_ready;
  logic [DATA_W-1:0]   wb_data;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   wr_data;
  logic                busy;

  modport master (
    input  req_valid, req_rd1, req_rd2, req_wr, req_src1, req_src2, req_dst,
    input  bus1, bus2, wb_valid, wb_data,
    output req_ready, rd1_sel, rd2_sel, op1, op2, op_valid, wb_ready,
    output wr_sel, wr_data, busy
  );

  modport slave (
    output req_valid, req_rd1, req_rd2, req_wr, req_src1, req_src2, req_dst,
    output bus1, bus2, wb_valid, wb_data,
    input  req_ready, rd1_sel, rd2_sel, op1, op2, op_valid, wb_ready,
    input  wr_sel, wr_data, busy
  );
endinterface

// File: rtl/regbus_controller.sv
// Register-bank bus initiator: drives read/save selects, captures operands, sequences one write-back.
// Define REGBUS_R0_ZERO_EN to make register index 0 read as zero and never be saved.
module regbus_controller #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  regbus_controller_if.master rb
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, READ, CAPT, WAIT_WB, WRITE} state_e;

  state_e              state_q, state_d;
  logic                rd1_q, rd1_d, rd2_q, rd2_d, wr_q, wr_d;
  logic [ADDR_W-1:0]   src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
  logic [NUM_REGS-1:0] rd1Sel_q, rd1Sel_d, rd2Sel_q, rd2Sel_d, wrSel_q, wrSel_d;
  logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d, wrData_q, wrData_d;
  logic                opValid_q, opValid_d, wbReady_q, wbReady_d;
  logic                reqReady_q, reqReady_d, busy_q, busy_d;

  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] idx);
    decode = '0;
`ifdef REGBUS_R0_ZERO_EN
    if (idx != '0) decode[idx] = 1'b1;
`else
    decode[idx] = 1'b1;
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    wr_d     = wr_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    dst_d    = dst_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    wrData_d = wrData_q;
    unique case (state_q)
      IDLE: begin
        if (rb.req_valid) begin
          rd1_d  = rb.req_rd1;
          rd2_d  = rb.req_rd2;
          wr_d   = rb.req_wr;
          src1_d = rb.req_src1;
          src2_d = rb.req_src2;
          dst_d  = rb.req_dst;
          if (rb.req_rd1 || rb.req_rd2) state_d = READ;
          else if (rb.req_wr)           state_d = WAIT_WB;
        end
      end
      READ: begin
`ifdef REGBUS_R0_ZERO_EN
        if (rd1_q) op1_d = (src1_q == '0) ? '0 : rb.bus1;
        if (rd2_q) op2_d = (src2_q == '0) ? '0 : rb.bus2;
`else
        if (rd1_q) op1_d = rb.bus1;
        if (rd2_q) op2_d = rb.bus2;
`endif
        state_d = CAPT;
      end
      CAPT:    state_d = wr_q ? WAIT_WB : IDLE;
      WAIT_WB: begin
        if (rb.wb_valid) begin
          wrData_d = rb.wb_data;
          state_d  = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the upcoming state so selects switch cleanly on the edge.
    rd1Sel_d   = (state_d == READ && rd1_d) ? decode(src1_d) : '0;
    rd2Sel_d   = (state_d == READ && rd2_d) ? decode(src2_d) : '0;
    wrSel_d    = (state_d == WRITE) ? decode(dst_d) : '0;
    opValid_d  = (state_d == CAPT);
    wbReady_d  = (state_d == WAIT_WB);
    reqReady_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd1_q      <= 1'b0;
      rd2_q      <= 1'b0;
      wr_q       <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      dst_q      <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      wrData_q   <= '0;
      rd1Sel_q   <= '0;
      rd2Sel_q   <= '0;
      wrSel_q    <= '0;
      opValid_q  <= 1'b0;
      wbReady_q  <= 1'b0;
      reqReady_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      wr_q       <= wr_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      dst_q      <= dst_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      wrData_q   <= wrData_d;
      rd1Sel_q   <= rd1Sel_d;
      rd2Sel_q   <= rd2Sel_d;
      wrSel_q    <= wrSel_d;
      opValid_q  <= opValid_d;
      wbReady_q  <= wbReady_d;
      reqReady_q <= reqReady_d;
      busy_q     <= busy_d;
    end
  end

  assign rb.req_ready = reqReady_q;
  assign rb.rd1_sel   = rd1Sel_q;
  assign rb.rd2_sel   = rd2Sel_q;
  assign rb.wr_sel    = wrSel_q;
  assign rb.op1       = op1_q;
  assign rb.op2       = op2_q;
  assign rb.op_valid  = opValid_q;
  assign rb.wb_ready  = wbReady_q;
  assign rb.wr_data   = wrData_q;
  assign rb.busy      = busy_q;
endmodule

// File: tb/tb_regbus_controller.sv
// Testbench for regbus_controller: emulated register bank on the shared buses plus a
// request-level reference model; honours REGBUS_R0_ZERO_EN when it is defined.
module tb_regbus_controller;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;

  typedef struct {
    bit       rd1;
    bit       rd2;
    bit       wr;
    bit [2:0] s1;
    bit [2:0] s2;
    bit [2:0] d;
    bit [7:0] wbData;
    int       wbDelay;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   monitorOn = 1'b0;

  logic [7:0] bank[NUM_REGS];
  logic [7:0] presetVals[NUM_REGS];
  logic [7:0] expRegs[NUM_REGS];
  logic [7:0] expOp1, expOp2;
  logic [7:0] floatVal1, floatVal2;

  regbus_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf();

  regbus_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .rb  (busIf.master)
  );

  always #5 clk = ~clk;

  // Emulated register bank: reloads its preset contents while rst is high, saves on wr_sel.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= presetVals[i];
    end else begin
      for (int i = 0; i < NUM_REGS; i++) if (busIf.wr_sel[i]) bank[i] <= busIf.wr_data;
    end
  end

  // Tri-state bus emulation: an undriven bus shows a random floating value.
  always_comb begin
    busIf.bus1 = floatVal1;
    busIf.bus2 = floatVal2;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (busIf.rd1_sel[i]) busIf.bus1 = bank[i];
      if (busIf.rd2_sel[i]) busIf.bus2 = bank[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] readModel(input logic [2:0] idx);
`ifdef REGBUS_R0_ZERO_EN
    if (idx == 3'd0) return 8'h00;
`endif
    return expRegs[idx];
  endfunction

  function automatic logic [7:0] selModel(input logic [2:0] idx);
`ifdef REGBUS_R0_ZERO_EN
    if (idx == 3'd0) return 8'h00;
`endif
    return 8'(1 << idx);
  endfunction

  function automatic req_t randReq();
    req_t r;
    r.rd1     = 1'($urandom_range(0, 1));
    r.rd2     = 1'($urandom_range(0, 1));
    r.wr      = 1'($urandom_range(0, 1));
    r.s1      = 3'($urandom_range(0, 7));
    r.s2      = 3'($urandom_range(0, 7));
    r.d       = 3'($urandom_range(0, 7));
    r.wbData  = 8'($urandom);
    r.wbDelay = $urandom_range(0, 3);
    return r;
  endfunction

  function automatic req_t mkReq(input bit rd1, input bit rd2, input bit wr, input bit [2:0] s1,
                                 input bit [2:0] s2, input bit [2:0] d, input bit [7:0] wbData,
                                 input int wbDelay);
    req_t r;
    r.rd1 = rd1; r.rd2 = rd2; r.wr = wr; r.s1 = s1; r.s2 = s2; r.d = d;
    r.wbData = wbData; r.wbDelay = wbDelay;
    return r;
  endfunction

  task automatic driveReq(input req_t r);
    busIf.req_valid = 1'b1;
    busIf.req_rd1   = r.rd1;
    busIf.req_rd2   = r.rd2;
    busIf.req_wr    = r.wr;
    busIf.req_src1  = r.s1;
    busIf.req_src2  = r.s2;
    busIf.req_dst   = r.d;
  endtask

  task automatic dropReq();
    busIf.req_valid = 1'b0;
    busIf.req_rd1   = 1'($urandom_range(0, 1));
    busIf.req_rd2   = 1'($urandom_range(0, 1));
    busIf.req_wr    = 1'($urandom_range(0, 1));
    busIf.req_src1  = 3'($urandom);
    busIf.req_src2  = 3'($urandom);
    busIf.req_dst   = 3'($urandom);
  endtask

  // Runs one request from offer to completion; called on a falling edge, returns on one in IDLE.
  // With chain set, the next request is presented while this one is still in flight.
  task automatic applyStimulus(input req_t r, input bit chain, input req_t nxt);
    int waitCycles;
    logic [7:0] e1, e2;
    logic [7:0] es1, es2;
    driveReq(r);
    floatVal1 = 8'($urandom);
    floatVal2 = 8'($urandom);
    waitCycles = 0;
    while (busIf.req_ready !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (busIf.req_ready !== 1'b1) begin
      checkOutput("accept_timeout", 32'(busIf.req_ready), 32'd1);
      dropReq();
      return;
    end
    e1  = r.rd1 ? readModel(r.s1) : expOp1;
    e2  = r.rd2 ? readModel(r.s2) : expOp2;
    es1 = r.rd1 ? selModel(r.s1) : 8'h00;
    es2 = r.rd2 ? selModel(r.s2) : 8'h00;
    @(negedge clk);
    if (chain) driveReq(nxt);
    else dropReq();
    checkOutput("busy_after_accept", 32'(busIf.busy), 32'(r.rd1 | r.rd2 | r.wr));
    if (r.rd1 || r.rd2) begin
      checkOutput("rd1_sel", 32'(busIf.rd1_sel), 32'(es1));
      checkOutput("rd2_sel", 32'(busIf.rd2_sel), 32'(es2));
      checkOutput("op_valid_early", 32'(busIf.op_valid), 32'd0);
      busIf.wb_valid = 1'($urandom_range(0, 1));
      busIf.wb_data  = 8'($urandom);
      @(negedge clk);
      checkOutput("op_valid", 32'(busIf.op_valid), 32'd1);
      checkOutput("op1", 32'(busIf.op1), 32'(e1));
      checkOutput("op2", 32'(busIf.op2), 32'(e2));
      checkOutput("rd_sel_capt", 32'(busIf.rd1_sel | busIf.rd2_sel), 32'd0);
      expOp1 = e1;
      expOp2 = e2;
      busIf.wb_valid = 1'($urandom_range(0, 1));
      busIf.wb_data  = 8'($urandom);
      @(negedge clk);
      busIf.wb_valid = 1'b0;
      checkOutput("op_valid_pulse", 32'(busIf.op_valid), 32'd0);
    end
    if (r.wr) begin
      checkOutput("wb_ready", 32'(busIf.wb_ready), 32'd1);
      repeat (r.wbDelay) begin
        busIf.wb_valid = 1'b0;
        busIf.wb_data  = 8'($urandom);
        @(negedge clk);
        checkOutput("wb_ready_hold", 32'(busIf.wb_ready), 32'd1);
        checkOutput("wr_sel_wait", 32'(busIf.wr_sel), 32'd0);
      end
      busIf.wb_valid = 1'b1;
      busIf.wb_data  = r.wbData;
      @(negedge clk);
      busIf.wb_valid = 1'b0;
      busIf.wb_data  = 8'($urandom);
      checkOutput("wr_sel", 32'(busIf.wr_sel), 32'(selModel(r.d)));
      checkOutput("wr_data", 32'(busIf.wr_data), 32'(r.wbData));
      checkOutput("wb_ready_drop", 32'(busIf.wb_ready), 32'd0);
`ifdef REGBUS_R0_ZERO_EN
      if (r.d != 3'd0) expRegs[r.d] = r.wbData;
`else
      expRegs[r.d] = r.wbData;
`endif
      @(negedge clk);
      checkOutput("wr_sel_pulse", 32'(busIf.wr_sel), 32'd0);
    end
    checkOutput("idle_ready", 32'(busIf.req_ready), 32'd1);
    checkOutput("idle_busy", 32'(busIf.busy), 32'd0);
  endtask

  // Structural invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (monitorOn && !rst) begin
      checkOutput("rd1_sel_onehot", 32'($countones(busIf.rd1_sel) <= 1), 32'd1);
      checkOutput("rd2_sel_onehot", 32'($countones(busIf.rd2_sel) <= 1), 32'd1);
      checkOutput("wr_sel_onehot", 32'($countones(busIf.wr_sel) <= 1), 32'd1);
      checkOutput("sel_overlap", 32'(((|busIf.rd1_sel) || (|busIf.rd2_sel)) && (|busIf.wr_sel)), 32'd0);
      checkOutput("ready_vs_busy", 32'(busIf.req_ready), 32'(!busIf.busy));
    end
  end

  initial begin
    req_t r, nxt;
    bit   chain;
    for (int i = 0; i < NUM_REGS; i++) presetVals[i] = 8'($urandom);
    presetVals[2] = 8'h3C;
    presetVals[7] = 8'hA5;
    presetVals[6] = 8'h11;
    for (int i = 0; i < NUM_REGS; i++) expRegs[i] = presetVals[i];
    expOp1 = 8'h00;
    expOp2 = 8'h00;
    floatVal1 = 8'hFF;
    floatVal2 = 8'hFF;
    busIf.wb_valid = 1'b0;
    busIf.wb_data  = 8'h00;
    dropReq();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 32'(busIf.req_ready), 32'd1);
    checkOutput("reset_busy", 32'(busIf.busy), 32'd0);
    checkOutput("reset_sels", 32'({busIf.rd1_sel, busIf.rd2_sel, busIf.wr_sel}), 32'd0);
    checkOutput("reset_ops", 32'({busIf.op1, busIf.op2, busIf.wr_data}), 32'd0);
    checkOutput("reset_pulses", 32'({busIf.op_valid, busIf.wb_ready}), 32'd0);
    rst = 1'b0;
    monitorOn = 1'b1;
    @(negedge clk);

    $display("[TB] reset asserted mid-READ");
    driveReq(mkReq(1, 0, 1, 3'd5, 3'd0, 3'd5, 8'h99, 0));
    @(negedge clk);
    dropReq();
    checkOutput("pre_reset_rd1_sel", 32'(busIf.rd1_sel), 32'h20);
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_drop_rd1_sel", 32'(busIf.rd1_sel), 32'd0);
    checkOutput("reset_drop_busy", 32'(busIf.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) expRegs[i] = presetVals[i];
    @(negedge clk);
    checkOutput("post_reset_ready", 32'(busIf.req_ready), 32'd1);
    checkOutput("post_reset_op1", 32'(busIf.op1), 32'd0);
    checkOutput("post_reset_wr_sel", 32'(busIf.wr_sel), 32'd0);

    $display("[TB] directed requests");
    applyStimulus(mkReq(1, 1, 0, 3'd2, 3'd7, 3'd0, 8'h00, 0), 0, r);
    applyStimulus(mkReq(0, 0, 1, 3'd0, 3'd0, 3'd3, 8'h5A, 4), 0, r);
    applyStimulus(mkReq(1, 0, 1, 3'd6, 3'd0, 3'd6, 8'h22, 1), 0, r);
    applyStimulus(mkReq(1, 1, 0, 3'd6, 3'd6, 3'd0, 8'h00, 0), 0, r);
    applyStimulus(mkReq(1, 1, 0, 3'd3, 3'd7, 3'd0, 8'h00, 0), 0, r);
    nxt = mkReq(1, 0, 1, 3'd4, 3'd0, 3'd1, 8'hC3, 2);
    applyStimulus(mkReq(1, 1, 0, 3'd1, 3'd4, 3'd0, 8'h00, 0), 1, nxt);
    applyStimulus(nxt, 0, r);
    applyStimulus(mkReq(0, 1, 0, 3'd0, 3'd1, 3'd0, 8'h00, 0), 0, r);
    applyStimulus(mkReq(0, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0), 0, r);
    applyStimulus(mkReq(1, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 0), 0, r);
    applyStimulus(mkReq(0, 0, 1, 3'd0, 3'd0, 3'd0, 8'h77, 1), 0, r);
    applyStimulus(mkReq(1, 1, 0, 3'd0, 3'd7, 3'd0, 8'h00, 0), 0, r);

    $display("[TB] randomized requests");
    r = randReq();
    for (int n = 0; n < 60; n++) begin
      nxt   = randReq();
      chain = 1'($urandom_range(0, 1));
      applyStimulus(r, chain, nxt);
      r = nxt;
    end
    for (int i = 0; i < NUM_REGS; i++)
      applyStimulus(mkReq(1, 1, 0, 3'(i), 3'(NUM_REGS - 1 - i), 3'd0, 8'h00, 0), 0, r);

    dropReq();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
